// File: rtl/stack_function_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stack_function_pkg: opcodes and FSM encoding for the operand stack |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package stack_function_pkg;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_PUSH  = 3'd1;
  localparam logic [2:0] OP_POP   = 3'd2;
  localparam logic [2:0] OP_DUP   = 3'd3;
  localparam logic [2:0] OP_SWAP  = 3'd4;
  localparam logic [2:0] OP_ROT3  = 3'd5;
  localparam logic [2:0] OP_CLEAR = 3'd6;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_REFILL = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/stack_ram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stack_ram: spill storage for entries below NOS, registered read    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module stack_ram #(
  parameter int DEPTH = 14,
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rd_q
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Same-address read during write yields the previous contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rd_q <= mem[raddr];
  end

endmodule
`default_nettype wire

// File: rtl/stack_function.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stack_function: operand stack, TOS/NOS in registers, rest in RAM   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module stack_function #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 12,
  parameter int ULA_WIDTH   = 24,
  parameter int STACK_DEPTH = 16,
  parameter int CNT_WIDTH   = 5
) (
  input  logic                  general_clk,
  input  logic                  general_reset,
  input  logic [2:0]            OP_IN,
  input  logic                  OP_VALID,
  output logic                  OP_READY,
  input  logic [ULA_WIDTH-1:0]  PUSH_IN,
  output logic [DATA_WIDTH-1:0] TOS_OUT,
  output logic [DATA_WIDTH-1:0] NOS_OUT,
  output logic [ADDR_WIDTH-1:0] STACK_FUNCTION_OUT,
  output logic [CNT_WIDTH-1:0]  COUNT_OUT,
  output logic                  OVERFLOW_OUT,
  output logic                  UNDERFLOW_OUT
);
  import stack_function_pkg::*;

  localparam int RAM_DEPTH = STACK_DEPTH - 2;
  localparam int RAM_AW    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(STACK_DEPTH);

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] tos, nos, tos_n, nos_n;
  logic [CNT_WIDTH-1:0]  count, count_n;
  logic                  ovf, unf, ovf_n, unf_n;
  logic                  go_refill;
  logic                  ram_we, ram_re;
  logic [RAM_AW-1:0]     ram_waddr, ram_raddr;
  logic [DATA_WIDTH-1:0] ram_wdata, rd_q;

  stack_ram #(.DEPTH(RAM_DEPTH), .WIDTH(DATA_WIDTH), .AW(RAM_AW)) u_ram (
    .clk   (general_clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rd_q  (rd_q)
  );

  always_ff @(posedge general_clk or negedge general_reset) begin
    if (!general_reset) state <= ST_IDLE;
    else                state <= state_next;
  end

  always_comb begin
    state_next = state;
    OP_READY   = (state == ST_IDLE);
    case (state)
      ST_IDLE:   if (OP_VALID && go_refill) state_next = ST_REFILL;
      ST_REFILL: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    tos_n     = tos;
    nos_n     = nos;
    count_n   = count;
    ovf_n     = ovf;
    unf_n     = unf;
    go_refill = 1'b0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_waddr = RAM_AW'(count - CNT_WIDTH'(2));
    ram_raddr = RAM_AW'(count - CNT_WIDTH'(3));
    ram_wdata = nos;
    if (state == ST_REFILL) begin
      nos_n = rd_q;
    end else if (OP_VALID) begin
      case (OP_IN)
        OP_PUSH, OP_DUP: begin
          if (OP_IN == OP_DUP && count == '0) begin
            unf_n = 1'b1;
          end else if (count == FULL) begin
            ovf_n = 1'b1;
          end else begin
            ram_we  = (count >= CNT_WIDTH'(2));
            nos_n   = tos;
            tos_n   = (OP_IN == OP_DUP) ? tos : PUSH_IN[DATA_WIDTH-1:0];
            count_n = count + CNT_WIDTH'(1);
          end
        end
        OP_POP: begin
          if (count == '0) begin
            unf_n = 1'b1;
          end else begin
            tos_n   = nos;
            count_n = count - CNT_WIDTH'(1);
            if (count >= CNT_WIDTH'(3)) begin
              ram_re    = 1'b1;
              go_refill = 1'b1;
            end
          end
        end
        OP_SWAP: begin
          if (count < CNT_WIDTH'(2)) begin
            unf_n = 1'b1;
          end else begin
            tos_n = nos;
            nos_n = tos;
          end
        end
        OP_ROT3: begin
          // Third entry is read out while old TOS overwrites its slot.
          if (count < CNT_WIDTH'(3)) begin
            unf_n = 1'b1;
          end else begin
            ram_we    = 1'b1;
            ram_waddr = ram_raddr;
            ram_wdata = tos;
            ram_re    = 1'b1;
            tos_n     = nos;
            go_refill = 1'b1;
          end
        end
        OP_CLEAR: begin
          tos_n   = '0;
          nos_n   = '0;
          count_n = '0;
          ovf_n   = 1'b0;
          unf_n   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge general_clk or negedge general_reset) begin
    if (!general_reset) begin
      tos   <= '0;
      nos   <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      tos   <= tos_n;
      nos   <= nos_n;
      count <= count_n;
      ovf   <= ovf_n;
      unf   <= unf_n;
    end
  end

  // Registers beyond the live count may hold stale data, so mask them.
  assign TOS_OUT            = (count != '0) ? tos : '0;
  assign NOS_OUT            = (count >= CNT_WIDTH'(2)) ? nos : '0;
  assign STACK_FUNCTION_OUT = {NOS_OUT[ADDR_WIDTH-DATA_WIDTH-1:0], TOS_OUT};
  assign COUNT_OUT          = count;
  assign OVERFLOW_OUT       = ovf;
  assign UNDERFLOW_OUT      = unf;

endmodule
`default_nettype wire

// File: tb/tb_stack_function.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_stack_function: vector table, corner sequences, random vs model |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_stack_function;
  import stack_function_pkg::*;

  localparam int SD = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  op_in;
  logic        op_valid;
  logic        op_ready;
  logic [23:0] push_in;
  logic [7:0]  tos_out, nos_out;
  logic [11:0] sf_out;
  logic [4:0]  count_out;
  logic        ovf_out, unf_out;

  stack_function #(
    .DATA_WIDTH(8), .ADDR_WIDTH(12), .ULA_WIDTH(24), .STACK_DEPTH(SD), .CNT_WIDTH(5)
  ) dut (
    .general_clk        (clk),
    .general_reset      (rst_n),
    .OP_IN              (op_in),
    .OP_VALID           (op_valid),
    .OP_READY           (op_ready),
    .PUSH_IN            (push_in),
    .TOS_OUT            (tos_out),
    .NOS_OUT            (nos_out),
    .STACK_FUNCTION_OUT (sf_out),
    .COUNT_OUT          (count_out),
    .OVERFLOW_OUT       (ovf_out),
    .UNDERFLOW_OUT      (unf_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: element 0 is the top of stack.
  logic [7:0] model[$];
  bit         m_ovf, m_unf;

  typedef struct {
    logic [2:0]  op;
    logic [23:0] d;
    logic [7:0]  tos;
    logic [7:0]  nos;
    logic [4:0]  cnt;
    logic        ovf;
    logic        unf;
  } vec_t;
  vec_t vt[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    model.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_apply(input logic [2:0] op, input logic [23:0] d);
    logic [7:0] t;
    int n;
    n = model.size();
    case (op)
      OP_PUSH: if (n < SD) model.push_front(d[7:0]); else m_ovf = 1'b1;
      OP_POP:  if (n > 0) t = model.pop_front(); else m_unf = 1'b1;
      OP_DUP: begin
        if (n == 0) m_unf = 1'b1;
        else if (n == SD) m_ovf = 1'b1;
        else begin t = model[0]; model.push_front(t); end
      end
      OP_SWAP: begin
        if (n < 2) m_unf = 1'b1;
        else begin t = model[0]; model[0] = model[1]; model[1] = t; end
      end
      OP_ROT3: begin
        if (n < 3) m_unf = 1'b1;
        else begin t = model[0]; model[0] = model[1]; model[1] = model[2]; model[2] = t; end
      end
      OP_CLEAR: model_reset();
      default: ;
    endcase
  endtask

  task automatic check_model(input string tag);
    logic [7:0] et, en;
    et = (model.size() >= 1) ? model[0] : 8'h00;
    en = (model.size() >= 2) ? model[1] : 8'h00;
    check({tag, ".tos"},   32'(tos_out),   32'(et));
    check({tag, ".nos"},   32'(nos_out),   32'(en));
    check({tag, ".jump"},  32'(sf_out),    32'({en[3:0], et}));
    check({tag, ".count"}, 32'(count_out), 32'(model.size()));
    check({tag, ".ovf"},   32'(ovf_out),   32'(m_ovf));
    check({tag, ".unf"},   32'(unf_out),   32'(m_unf));
  endtask

  // Issue one operation, then count negedges with OP_READY low before it returns.
  task automatic do_op(input logic [2:0] op, input logic [23:0] d, output int busy);
    @(negedge clk);
    op_in = op;
    push_in = d;
    op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_in = OP_NOP;
    busy = 0;
    @(negedge clk);
    while (!op_ready && busy < 8) begin
      busy++;
      @(negedge clk);
    end
    if (!op_ready) begin
      failures++;
      checks++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [23:0] d, input string tag);
    int b, eb;
    eb = ((op == OP_POP || op == OP_ROT3) && model.size() >= 3) ? 1 : 0;
    do_op(op, d, b);
    model_apply(op, d);
    check({tag, ".busy"}, 32'(b), 32'(eb));
    check_model(tag);
  endtask

  task automatic apply_reset();
    op_valid = 1'b0;
    op_in = OP_NOP;
    push_in = '0;
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int b;
    logic [2:0] op;
    int r;

    vt[0]  = '{OP_PUSH,  24'h000011, 8'h11, 8'h00, 5'd1, 1'b0, 1'b0};
    vt[1]  = '{OP_PUSH,  24'hFF0A3,  8'hA3, 8'h11, 5'd2, 1'b0, 1'b0};
    vt[2]  = '{OP_SWAP,  24'h0,      8'h11, 8'hA3, 5'd2, 1'b0, 1'b0};
    vt[3]  = '{OP_DUP,   24'h0,      8'h11, 8'h11, 5'd3, 1'b0, 1'b0};
    vt[4]  = '{OP_ROT3,  24'h0,      8'h11, 8'hA3, 5'd3, 1'b0, 1'b0};
    vt[5]  = '{OP_POP,   24'h0,      8'hA3, 8'h11, 5'd2, 1'b0, 1'b0};
    vt[6]  = '{OP_POP,   24'h0,      8'h11, 8'h00, 5'd1, 1'b0, 1'b0};
    vt[7]  = '{OP_SWAP,  24'h0,      8'h11, 8'h00, 5'd1, 1'b0, 1'b1};
    vt[8]  = '{3'd7,     24'h0,      8'h11, 8'h00, 5'd1, 1'b0, 1'b1};
    vt[9]  = '{OP_CLEAR, 24'h0,      8'h00, 8'h00, 5'd0, 1'b0, 1'b0};
    vt[10] = '{OP_POP,   24'h0,      8'h00, 8'h00, 5'd0, 1'b0, 1'b1};
    vt[11] = '{OP_DUP,   24'h0,      8'h00, 8'h00, 5'd0, 1'b0, 1'b1};
    vt[12] = '{OP_PUSH,  24'h000123, 8'h23, 8'h00, 5'd1, 1'b0, 1'b1};

    apply_reset();
    #1;
    check("reset.tos",   32'(tos_out),   32'h0);
    check("reset.nos",   32'(nos_out),   32'h0);
    check("reset.count", 32'(count_out), 32'h0);
    check("reset.ready", 32'(op_ready),  32'h1);
    check("reset.flags", 32'({ovf_out, unf_out}), 32'h0);

    foreach (vt[i]) begin
      do_op(vt[i].op, vt[i].d, b);
      check($sformatf("vec%0d.tos", i),   32'(tos_out),   32'(vt[i].tos));
      check($sformatf("vec%0d.nos", i),   32'(nos_out),   32'(vt[i].nos));
      check($sformatf("vec%0d.jump", i),  32'(sf_out),    32'({vt[i].nos[3:0], vt[i].tos}));
      check($sformatf("vec%0d.count", i), 32'(count_out), 32'(vt[i].cnt));
      check($sformatf("vec%0d.ovf", i),   32'(ovf_out),   32'(vt[i].ovf));
      check($sformatf("vec%0d.unf", i),   32'(unf_out),   32'(vt[i].unf));
    end

    // POP from depth 4 refills NOS from RAM with a single busy cycle
    apply_reset();
    for (int i = 1; i <= 4; i++) run_op(OP_PUSH, 24'(i), "s2push");
    run_op(OP_POP, 24'h0, "s2pop");
    check("s2.tos", 32'(tos_out), 32'h03);
    check("s2.nos", 32'(nos_out), 32'h02);

    // ROT3 with 01,02,03 then two POPs
    run_op(OP_CLEAR, 24'h0, "s3clr");
    for (int i = 1; i <= 3; i++) run_op(OP_PUSH, 24'(i), "s3push");
    run_op(OP_ROT3, 24'h0, "s3rot");
    check("s3rot.tos", 32'(tos_out), 32'h02);
    check("s3rot.nos", 32'(nos_out), 32'h01);
    run_op(OP_POP, 24'h0, "s3pop1");
    run_op(OP_POP, 24'h0, "s3pop2");
    check("s3.tos", 32'(tos_out), 32'h03);
    check("s3.count", 32'(count_out), 32'h1);

    // Fill to capacity, overflow, then clear
    run_op(OP_CLEAR, 24'h0, "s4clr");
    for (int i = 0; i < SD; i++) run_op(OP_PUSH, 24'($urandom), "s4push");
    run_op(OP_PUSH, 24'h55, "s4ovf");
    check("s4.ovf", 32'(ovf_out), 32'h1);
    check("s4.count", 32'(count_out), 32'(SD));
    run_op(OP_DUP, 24'h0, "s4dupovf");
    run_op(OP_CLEAR, 24'h0, "s4clr2");
    check("s4clr.flags", 32'({ovf_out, unf_out}), 32'h0);

    // Underflow cases at counts 0, 1, 2
    run_op(OP_POP, 24'h0, "s5pop");
    run_op(OP_PUSH, 24'h7, "s5push1");
    run_op(OP_SWAP, 24'h0, "s5swap");
    run_op(OP_PUSH, 24'h8, "s5push2");
    run_op(OP_ROT3, 24'h0, "s5rot");
    check("s5.unf", 32'(unf_out), 32'h1);

    // Asynchronous reset during the refill cycle
    run_op(OP_CLEAR, 24'h0, "s6clr");
    for (int i = 0; i < 5; i++) run_op(OP_PUSH, 24'(8'h40 + i), "s6push");
    @(negedge clk);
    op_in = OP_POP;
    op_valid = 1'b1;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_in = OP_NOP;
    #1;
    check("s6.busy", 32'(op_ready), 32'h0);
    rst_n = 1'b0;
    #1;
    check("s6.count", 32'(count_out), 32'h0);
    check("s6.ready", 32'(op_ready),  32'h1);
    check("s6.tos",   32'(tos_out),   32'h0);
    check("s6.jump",  32'(sf_out),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_op(OP_PUSH, 24'h11, "s6p1");
    run_op(OP_PUSH, 24'hFF0A3, "s6p2");
    check("s6.final_jump", 32'(sf_out), 32'h1A3);

    // Randomized operations against the model
    run_op(OP_CLEAR, 24'h0, "rclr");
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 3)      op = OP_PUSH;
      else if (r <= 5) op = OP_POP;
      else if (r == 6) op = OP_DUP;
      else if (r == 7) op = OP_SWAP;
      else if (r == 8) op = OP_ROT3;
      else             op = 3'($urandom_range(0, 7));
      run_op(op, 24'($urandom), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stack_function.md
Name: stack_function

Overview:
- Operand data stack for the pamPy stack machine.
- It accepts results written by the ULA datapath (push side) and supplies top-of-stack and next-of-stack operands, plus a combined jump target, back to the ULA and PC blocks (read side).
- The top two entries are held in registers. Deeper entries live in a synchronous-read RAM array.
- Operations use a valid/ready handshake. A two-state FSM covers the RAM refill cycle.

Parameters:
- DATA_WIDTH, 8, width of one stack entry.
- ADDR_WIDTH, 12, jump-target width. Legal range is DATA_WIDTH+1 .. 2*DATA_WIDTH.
- ULA_WIDTH, 24, width of the push data input.
- STACK_DEPTH, 16, maximum number of entries. Must be at least 3.
- CNT_WIDTH, 5, count width, equal to clog2(STACK_DEPTH+1).

Ports:
- general_clk  in  1  clock; all state updates on the rising edge.
- general_reset  in  1  asynchronous, active-low reset.
- OP_IN  in  3  operation code.
- OP_VALID  in  1  operation request.
- OP_READY  out  1  block can accept an operation this cycle.
- PUSH_IN  in  ULA_WIDTH  push data; only the low DATA_WIDTH bits are used.
- TOS_OUT  out  DATA_WIDTH  top of stack; 0 when count is 0.
- NOS_OUT  out  DATA_WIDTH  next of stack; 0 when count is less than 2.
- STACK_FUNCTION_OUT  out  ADDR_WIDTH  jump target, formed as {NOS_OUT[ADDR_WIDTH-DATA_WIDTH-1:0], TOS_OUT}.
- COUNT_OUT  out  CNT_WIDTH  current entry count.
- OVERFLOW_OUT  out  1  sticky overflow flag.
- UNDERFLOW_OUT  out  1  sticky underflow flag.

Behaviour:
- Reset (asynchronous, general_reset=0):
  - TOS and NOS registers = 0.
  - count = 0.
  - Both flags = 0.
  - FSM = IDLE, so OP_READY = 1.
  - RAM contents are don't-care.
- Storage layout: TOS register holds entry 1, NOS register holds entry 2. Entry k (k≥3) lives at mem[count-k].
- Handshake:
  - An operation is accepted on an edge where OP_VALID=1 and OP_READY=1.
  - OP_READY = 1 exactly when FSM = IDLE.
  - OP_VALID while not ready is ignored; the requester must hold the operation until accepted.
- FSM states:
  - IDLE: accepts operations.
  - REFILL: one cycle long; on its edge NOS <= rd_q and FSM -> IDLE.
  - Only POP and ROT3 with count≥3 enter REFILL. All other operations complete in one cycle.
- RAM: registered read, rd_q <= mem[addr] at the accept edge. Read-during-write to the same address returns old data.
- Opcodes:
  - 0 NOP: no change.
  - 1 PUSH: if count<STACK_DEPTH, then mem[count-2] <= NOS (only when count≥2), NOS <= TOS, TOS <= PUSH_IN[DATA_WIDTH-1:0], count+1. If full: OVERFLOW_OUT=1 and no state change.
  - 2 POP: if count≥1, then TOS <= NOS and count-1. When count≥3, also rd_q <= mem[count-3] and FSM -> REFILL. If count=0: UNDERFLOW_OUT=1.
  - 3 DUP: needs count≥1 (else underflow) and count<STACK_DEPTH (else overflow). Same as PUSH, with TOS as the pushed data.
  - 4 SWAP: needs count≥2, else underflow. Exchanges TOS and NOS in one cycle.
  - 5 ROT3: needs count≥3, else underflow. mem[count-3] <= TOS, TOS <= NOS, rd_q <= old mem[count-3], FSM -> REFILL. Result: old TOS moves to third position, third moves to NOS.
  - 6 CLEAR: count = 0, TOS = NOS = 0, both flags cleared.
  - 7: reserved; treated as NOP.
- Error handling:
  - A faulting operation makes no state change other than setting its flag, and completes in one cycle.
  - When a flag is set, the other flag keeps its value.
- Output timing:
  - Outputs reflect the new state on the cycle after the accept edge.
  - For REFILL operations, NOS_OUT and STACK_FUNCTION_OUT are valid only once OP_READY returns to 1.
- Reset during REFILL: the FSM aborts to IDLE with all reset values.

Decomposition:
- Package stack_function_pkg holds:
  - opcode localparams OP_NOP..OP_CLEAR (3-bit);
  - FSM state encoding (IDLE, REFILL).
- One sub-module, stack_ram:
  - depth STACK_DEPTH-2, width DATA_WIDTH;
  - single write port plus single registered read port;
  - no reset.

Test Plan:
1. Reset, PUSH 0x11, then PUSH 0x0A3 (PUSH_IN=0xFF0A3) -> TOS=0xA3, NOS=0x11, COUNT=2, STACK_FUNCTION_OUT=0x1A3, OP_READY high throughout.
2. PUSH 0x01, 0x02, 0x03, 0x04, then POP -> OP_READY low for exactly 1 cycle after accept; then TOS=0x03, NOS=0x02, COUNT=3.
3. Stack holding 0x01, 0x02, 0x03 (TOS=0x03), ROT3 -> TOS=0x02, NOS=0x01, third=0x03; two POPs then give TOS=0x03 and COUNT=1.
4. 16 PUSHes, then a 17th PUSH 0x55 -> OVERFLOW_OUT=1, COUNT=16, TOS unchanged; CLEAR -> COUNT=0, both flags 0, TOS_OUT=0.
5. Empty stack: POP, SWAP with COUNT=1, ROT3 with COUNT=2 -> UNDERFLOW_OUT=1 each time, COUNT unchanged, one-cycle completion.
6. Assert general_reset low during the REFILL cycle of a POP at COUNT=5 -> COUNT=0, OP_READY=1, outputs 0 immediately (asynchronous); the first PUSH after release behaves as in scenario 1.
